// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock through a ripple stage, valid/ready on both sides.
// Optional saturation of signed-overflow results when ADDSUB_SATURATE_EN is defined.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_cfg_check
    $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  a_r, b_r, y_r;
  logic              carry_r, cout_r, ovf_r, zero_r, out_valid_r;
  logic              accept_s, last_s, ovf_s;
  int                sh_s;
  logic [CHUNK-1:0]  a_chunk_s, b_chunk_s;
  logic [CHUNK:0]    sum_s;
  logic [WIDTH-1:0]  y_wrap_s, y_fin_s;

  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  function automatic logic ovf_f(input logic am, input logic bm, input logic ym);
    return (am == bm) && (ym != am);
  endfunction

`ifdef ADDSUB_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_f(input logic am);
    return am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign last_s    = (cnt_r == CW'(NCHUNK - 1));
  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = CALC;
        else          state_nxt_s = IDLE;
      end
      CALC: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = CALC;
      end
      DONE: begin
        if (accept_s)       state_nxt_s = CALC;
        else if (out_ready) state_nxt_s = IDLE;
        else                state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Chunk ripple stage, result merge and final flag/saturation evaluation
  always_comb begin
    sh_s      = CHUNK * int'(cnt_r);
    a_chunk_s = CHUNK'(a_r >> sh_s);
    b_chunk_s = CHUNK'(b_r >> sh_s);
    sum_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    y_wrap_s  = (y_r & ~(CHUNK_MASK << sh_s)) | (WIDTH'(sum_s[CHUNK-1:0]) << sh_s);
    ovf_s     = ovf_f(a_r[WIDTH-1], b_r[WIDTH-1], y_wrap_s[WIDTH-1]);
    y_fin_s   = y_wrap_s;
`ifdef ADDSUB_SATURATE_EN
    if (last_s && ovf_s) y_fin_s = sat_f(a_r[WIDTH-1]);
    else                 y_fin_s = y_wrap_s;
`endif
  end

  // Operand capture, per-chunk accumulation and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      a_r         <= a;
      b_r         <= b ^ {WIDTH{sub}};
      carry_r     <= sub;
      cnt_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
    end else if (state_r == CALC) begin
      y_r     <= y_fin_s;
      carry_r <= sum_s[CHUNK];
      if (last_s) begin
        cnt_r       <= {CW{1'b0}};
        cout_r      <= sum_s[CHUNK];
        ovf_r       <= ovf_s;
        zero_r      <= (y_fin_s == {WIDTH{1'b0}});
        out_valid_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else if ((state_r == DONE) && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: default 16/4 instance plus 16/16 and 8/2 instances.
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        iv0, ir0, s0, ov0, or0, c0, f0, z0;
  logic [15:0] a0, b0, y0;
  logic        iv1, ir1, s1, ov1, or1, c1, f1, z1;
  logic [15:0] a1, b1, y1;
  logic        iv2, ir2, s2, ov2, or2, c2, f2, z2;
  logic [7:0]  a2, b2, y2;

  addsub_seq #(.WIDTH(16), .CHUNK(4)) d0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .sub(s0),
    .out_valid(ov0), .out_ready(or0), .y(y0), .cout(c0), .ovf(f0), .zero(z0));
  addsub_seq #(.WIDTH(16), .CHUNK(16)) d1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .sub(s1),
    .out_valid(ov1), .out_ready(or1), .y(y1), .cout(c1), .ovf(f1), .zero(z1));
  addsub_seq #(.WIDTH(8), .CHUNK(2)) d2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .sub(s2),
    .out_valid(ov2), .out_ready(or2), .y(y2), .cout(c2), .ovf(f2), .zero(z2));

  // d0 operation; garbage is driven with in_valid high during CALC to prove it is ignored
  task automatic do_op0(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] ey, input logic ec, input logic eo, input logic ez,
                        input logic keep, input string nm);
    int lat;
    iv0 = 1'b1; a0 = a; b0 = b; s0 = s;
    @(posedge clk); #1;
    a0 = 16'hDEAD; b0 = 16'hBEEF; s0 = ~s;
    n_cmp++;
    if (ir0 !== 1'b0) begin n_err++; $display("FAIL %s busy: in_ready=%b want 0", nm, ir0); end
    lat = 0;
    while (!ov0 && lat < 20) begin @(posedge clk); #1; lat++; end
    iv0 = 1'b0;
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL %s latency: got %0d want 4", nm, lat); end
    n_cmp++;
    if ({y0, c0, f0, z0} !== {ey, ec, eo, ez}) begin
      n_err++;
      $display("FAIL %s result: y=%h c=%b o=%b z=%b want y=%h c=%b o=%b z=%b",
               nm, y0, c0, f0, z0, ey, ec, eo, ez);
    end
    if (!keep) begin
      or0 = 1'b1;
      @(posedge clk); #1;
      or0 = 1'b0;
      n_cmp++;
      if ({ov0, ir0} !== 2'b01) begin
        n_err++; $display("FAIL %s release: out_valid=%b in_ready=%b want 0 1", nm, ov0, ir0);
      end
    end
  endtask

  task automatic test_reset();
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ov0, y0, c0, f0, z0, ir0} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
      n_err++; $display("FAIL reset_init: ov=%b y=%h c=%b o=%b z=%b rdy=%b want 0 0000 0 0 0 1",
                        ov0, y0, c0, f0, z0, ir0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    iv0 = 1'b1; a0 = 16'h1234; b0 = 16'h0FED; s0 = 1'b0;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ov0, y0, c0, f0, z0, ir0} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
      n_err++; $display("FAIL reset_midcalc: ov=%b y=%h c=%b o=%b z=%b rdy=%b want 0 0000 0 0 0 1",
                        ov0, y0, c0, f0, z0, ir0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen = seen | ov0; end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL reset_discard: out_valid seen=%b want 0", seen); end
  endtask

  task automatic test_arith();
    do_op0(16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0, 1'b0, "add");
    do_op0(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "sub_zero");
`ifdef ADDSUB_SATURATE_EN
    do_op0(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, "pos_ovf");
    do_op0(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, "neg_ovf");
`else
    do_op0(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, "pos_ovf");
    do_op0(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, "neg_ovf");
`endif
    do_op0(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, "chunk_carry");
    do_op0(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "wrap_add");
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op0(16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0, 1'b1, "hold_first");
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({ov0, ir0, y0, c0, f0, z0} !== {2'b10, 16'h2221, 3'b000}) begin
        n_err++; $display("FAIL hold: ov=%b rdy=%b y=%h c=%b o=%b z=%b want 1 0 2221 0 0 0",
                          ov0, ir0, y0, c0, f0, z0);
      end
    end
    or0 = 1'b1; iv0 = 1'b1; a0 = 16'h0003; b0 = 16'h0005; s0 = 1'b1;
    #1;
    n_cmp++;
    if (ir0 !== 1'b1) begin n_err++; $display("FAIL b2b_ready: in_ready=%b want 1", ir0); end
    @(posedge clk); #1;
    iv0 = 1'b0; or0 = 1'b0;
    n_cmp++;
    if ({ov0, ir0} !== 2'b00) begin
      n_err++; $display("FAIL b2b_accept: out_valid=%b in_ready=%b want 0 0", ov0, ir0);
    end
    lat = 0;
    while (!ov0 && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    n_cmp++;
    if ({y0, c0, f0, z0} !== {16'hFFFE, 3'b000}) begin
      n_err++; $display("FAIL b2b_result: y=%h c=%b o=%b z=%b want FFFE 0 0 0", y0, c0, f0, z0);
    end
    or0 = 1'b1;
    @(posedge clk); #1;
    or0 = 1'b0;
  endtask

  task automatic test_chunk16();
    int lat;
    iv1 = 1'b1; a1 = 16'h1234; b1 = 16'h0FED; s1 = 1'b0;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL c16_latency: got %0d want 1", lat); end
    n_cmp++;
    if ({y1, c1, f1, z1} !== {16'h2221, 3'b000}) begin
      n_err++; $display("FAIL c16_result: y=%h c=%b o=%b z=%b want 2221 0 0 0", y1, c1, f1, z1);
    end
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
  endtask

  task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [10:0] exp_r, input string nm);
    int lat;
    iv2 = 1'b1; a2 = a; b2 = b; s2 = s;
    @(posedge clk); #1;
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL %s latency: got %0d want 4", nm, lat); end
    n_cmp++;
    if ({y2, c2, f2, z2} !== exp_r) begin
      n_err++; $display("FAIL %s result: {y,c,o,z}=%h want %h", nm, {y2, c2, f2, z2}, exp_r);
    end
    or2 = 1'b1;
    @(posedge clk); #1;
    or2 = 1'b0;
  endtask

  task automatic test_width8();
    op2(8'hFF, 8'h01, 1'b0, {8'h00, 3'b101}, "w8_wrap");
`ifdef ADDSUB_SATURATE_EN
    op2(8'h7F, 8'h01, 1'b0, {8'h7F, 3'b010}, "w8_ovf");
`else
    op2(8'h7F, 8'h01, 1'b0, {8'h80, 3'b010}, "w8_ovf");
`endif
  endtask

  initial begin
    iv0 = 1'b0; a0 = 16'h0000; b0 = 16'h0000; s0 = 1'b0; or0 = 1'b0;
    iv1 = 1'b0; a1 = 16'h0000; b1 = 16'h0000; s1 = 1'b0; or1 = 1'b0;
    iv2 = 1'b0; a2 = 8'h00;    b2 = 8'h00;    s2 = 1'b0; or2 = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_chunk16();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
